sccb_cfg_sequencer: RTL

- Walks the camera register-configuration LUT (index → {reg_addr, reg_data}, plus a size output) from index 0 to size-1.
- For each entry it issues one SCCB/I2C transaction to the shared I2C master core: reads for the leading ID entries, writes for the rest.
- Handles the power-up delay, the post-soft-reset wait, NACK retries and ID checking.
- Raises done or error for the capture pipeline and the top-level status LEDs.

---
 rtl/sccb_cfg_sequencer_if.sv | 22 ++
 rtl/sccb_cfg_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_sequencer_if.sv
// Request/response bundle between the configuration sequencer and the shared I2C master core.
// The sequencer holds the request fields steady while req is high; the core answers with a one-cycle done pulse.
interface sccb_cfg_sequencer_if;
  logic       req;
  logic       rw;
  logic [7:0] dev;
  logic [7:0] regAddr;
  logic [7:0] wdata;
  logic       done;
  logic       nack;
  logic [7:0] rdata;

  modport master (
    output req, rw, dev, regAddr, wdata,
    input  done, nack, rdata
  );

  modport slave (
    input  req, rw, dev, regAddr, wdata,
    output done, nack, rdata
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// Walks the camera register LUT and issues one SCCB transaction per entry: reads for the ID entries, writes for the rest.
// Covers the power-up delay, the wait after a sensor soft reset, NACK retries and the ID check.
module sccb_cfg_sequencer #(
  parameter logic [19:0] INIT_DELAY = 20'd1000000,
  parameter logic [19:0] RESET_WAIT = 20'd50000,
  parameter logic [7:0]  READ_NUM   = 8'd2,
  parameter logic [2:0]  MAX_RETRY  = 3'd3,
  parameter logic [7:0]  DEV_ADDR   = 8'h42
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cfg_restart_i,
  output logic [7:0]                  lut_index_o,
  input  logic [15:0]                 lut_data_i,
  input  logic [7:0]                  lut_size_i,
  sccb_cfg_sequencer_if.master        bus,
  output logic                        cfg_done_o,
  output logic                        cfg_error_o,
  output logic                        id_mismatch_o
);

  typedef enum logic [2:0] {
    INIT, LOAD, ISSUE, XFER, RWAIT, NEXT, DONE, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lutIndex_q, lutIndex_d;
  logic        req_q, req_d;
  logic        rw_q, rw_d;
  logic [7:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        mismatch_q, mismatch_d;
  logic [19:0] delayCnt_q, delayCnt_d;
  logic [2:0]  retryCnt_q, retryCnt_d;
  logic        issueRead;

  assign issueRead = (lutIndex_q < READ_NUM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      lutIndex_q <= '0;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      dev_q      <= DEV_ADDR;
      reg_q      <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mismatch_q <= 1'b0;
      delayCnt_q <= '0;
      retryCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lutIndex_q <= lutIndex_d;
      req_q      <= req_d;
      rw_q       <= rw_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mismatch_q <= mismatch_d;
      delayCnt_q <= delayCnt_d;
      retryCnt_q <= retryCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lutIndex_d = lutIndex_q;
    req_d      = req_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    error_d    = error_q;
    mismatch_d = mismatch_q;
    delayCnt_d = delayCnt_q;
    retryCnt_d = retryCnt_q;

    unique case (state_q)
      INIT: begin
        if (delayCnt_q == INIT_DELAY - 20'd1) begin
          delayCnt_d = '0;
          if (lut_size_i == 8'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          delayCnt_d = delayCnt_q + 20'd1;
        end
      end
      LOAD: state_d = ISSUE;
      ISSUE: begin
        reg_d   = lut_data_i[15:8];
        wdata_d = lut_data_i[7:0];
        rw_d    = issueRead;
        dev_d   = DEV_ADDR | {7'd0, issueRead};
        req_d   = 1'b1;
        state_d = XFER;
      end
      XFER: begin
        // A response is only acted on here; a stray done seen in any other state is dropped.
        if (bus.done) begin
          req_d = 1'b0;
          if (bus.nack) begin
            if (retryCnt_q < MAX_RETRY) begin
              retryCnt_d = retryCnt_q + 3'd1;
              state_d    = ISSUE;
            end else begin
              state_d = ERROR;
              error_d = 1'b1;
            end
          end else begin
            retryCnt_d = '0;
            if (rw_q) begin
              if (bus.rdata != wdata_q) mismatch_d = 1'b1;
              state_d = NEXT;
            end else if (reg_q == 8'h12 && wdata_q[7]) begin
              state_d = RWAIT;
            end else begin
              state_d = NEXT;
            end
          end
        end
      end
      RWAIT: begin
        if (delayCnt_q == RESET_WAIT - 20'd1) begin
          delayCnt_d = '0;
          state_d    = NEXT;
        end else begin
          delayCnt_d = delayCnt_q + 20'd1;
        end
      end
      NEXT: begin
        if (lutIndex_q == lut_size_i - 8'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          lutIndex_d = lutIndex_q + 8'd1;
          state_d    = LOAD;
        end
      end
      DONE:    done_d  = 1'b1;
      ERROR:   error_d = 1'b1;
      default: state_d = INIT;
    endcase

    // Restart overrides whatever the walk was doing; an in-flight byte is left to the master to finish.
    if (cfg_restart_i) begin
      state_d    = INIT;
      delayCnt_d = '0;
      retryCnt_d = '0;
      lutIndex_d = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      mismatch_d = 1'b0;
      req_d      = 1'b0;
    end
  end

  assign lut_index_o   = lutIndex_q;
  assign bus.req       = req_q;
  assign bus.rw        = rw_q;
  assign bus.dev       = dev_q;
  assign bus.regAddr   = reg_q;
  assign bus.wdata     = wdata_q;
  assign cfg_done_o    = done_q;
  assign cfg_error_o   = error_q;
  assign id_mismatch_o = mismatch_q;

endmodule
